// File: rtl/ghost_unit.sv
// Ghost sprite renderer and mode controller: hit-tests the current pixel
// against the ghost tile, looks up a two-frame bitmap, and runs the
// NORMAL/FRIGHT/FLASH/EATEN mode machine with collision pulses.
module ghost_unit #(
    parameter int unsigned TILE          = 21,
    parameter int unsigned X_ORIGIN      = 100,
    parameter int unsigned Y_ORIGIN      = 9,
    parameter int unsigned COORD_W       = 5,
    parameter int unsigned FRIGHT_FRAMES = 360,
    parameter int unsigned FLASH_FRAMES  = 120,
    parameter int unsigned ANIM_FRAMES   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               gameover,
    input  logic               power_pill,
    input  logic               frame_tick,
    input  logic [9:0]         x,
    input  logic [8:0]         y,
    input  logic [COORD_W-1:0] ghost_x,
    input  logic [COORD_W-1:0] ghost_y,
    input  logic [COORD_W-1:0] pac_x,
    input  logic [COORD_W-1:0] pac_y,
    input  logic               ghost_home,
    output logic               ghost_on,
    output logic [1:0]         ghost_color,
    output logic [1:0]         mode,
    output logic               pac_killed,
    output logic               ghost_eaten
);

    localparam int unsigned TW  = $clog2(FRIGHT_FRAMES + 1);
    localparam int unsigned AW  = 16;
    localparam int unsigned ACW = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;

    typedef enum logic [1:0] {
        M_NORMAL = 2'd0,
        M_FRIGHT = 2'd1,
        M_FLASH  = 2'd2,
        M_EATEN  = 2'd3
    } mode_e;

    mode_e            mode_q, mode_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             anim_q, anim_d;
    logic [ACW-1:0]   acnt_q, acnt_d;
    logic             armed_q;
    logic             ghost_on_q, ghost_on_d;
    logic [1:0]       color_q, color_d;
    logic             killed_q, killed_d;
    logic             eaten_q, eaten_d;

    logic             collide;
    logic [AW-1:0]    x_w, y_w, x_lo, y_lo, sx, sy;
    logic             hit, pix, eyes_ok;
    logic [20:0]      row;

    // Frame A: standard ghost body, MSB is the leftmost column.
    function automatic logic [20:0] frame_a_row(input logic [4:0] r);
        logic [20:0] v;
        case (r)
            5'd0:                      v = 21'b000000011111110000000;
            5'd1:                      v = 21'b000011111111111110000;
            5'd2:                      v = 21'b001111111111111111100;
            5'd3, 5'd4:                v = 21'b011111111111111111110;
            5'd5, 5'd10:               v = 21'b111100111111111001111;
            5'd6, 5'd7, 5'd8, 5'd9:    v = 21'b111000011111110000111;
            5'd11, 5'd12, 5'd13, 5'd14,
            5'd15, 5'd16, 5'd17:       v = 21'b111111111111111111111;
            5'd18:                     v = 21'b110011100111001110011;
            5'd19:                     v = 21'b100001100011000110001;
            default:                   v = '0;
        endcase
        return v;
    endfunction

    assign collide = (ghost_x == pac_x) && (ghost_y == pac_y);

    // Pixel hit test and bitmap lookup in wide arithmetic to avoid overflow.
    always_comb begin
        x_w  = AW'(x);
        y_w  = AW'(y);
        x_lo = AW'(X_ORIGIN) + AW'(ghost_x) * AW'(TILE);
        y_lo = AW'(Y_ORIGIN) + AW'(ghost_y) * AW'(TILE);
        hit  = (x_w >= x_lo) && (x_w < x_lo + AW'(TILE)) &&
               (y_w >= y_lo) && (y_w < y_lo + AW'(TILE));
        sx   = x_w - x_lo;
        sy   = y_w - y_lo;
        row  = '0;
        pix  = 1'b0;
        if (hit && (sx < AW'(21)) && (sy < AW'(21))) begin
            row = frame_a_row(sy[4:0]);
            if (anim_q && ((sy == AW'(18)) || (sy == AW'(19)))) begin
                row = row >> 1;
            end
            pix = row[5'd20 - sx[4:0]];
        end
        eyes_ok    = (mode_q != M_EATEN) || ((sy >= AW'(5)) && (sy <= AW'(10)));
        ghost_on_d = hit && pix && !gameover && eyes_ok;
    end

    // Palette selection from the current mode and animation phase.
    always_comb begin
        color_d = 2'b00;
        case (mode_q)
            M_NORMAL: color_d = 2'b00;
            M_FRIGHT: color_d = 2'b01;
            M_FLASH:  color_d = anim_q ? 2'b10 : 2'b01;
            M_EATEN:  color_d = 2'b11;
            default:  color_d = 2'b00;
        endcase
    end

    // Animation phase counter advanced by frame ticks.
    always_comb begin
        acnt_d = acnt_q;
        anim_d = anim_q;
        if (frame_tick) begin
            if (acnt_q == ACW'(ANIM_FRAMES - 1)) begin
                acnt_d = '0;
                anim_d = ~anim_q;
            end else begin
                acnt_d = acnt_q + ACW'(1);
            end
        end
    end

    // Mode next-state in priority order, plus collision pulses.
    always_comb begin
        mode_d   = mode_q;
        timer_d  = timer_q;
        eaten_d  = 1'b0;
        killed_d = collide && (mode_q == M_NORMAL) && !gameover && armed_q;
        if (gameover) begin
            mode_d  = M_NORMAL;
            timer_d = '0;
        end else if (collide && ((mode_q == M_FRIGHT) || (mode_q == M_FLASH))) begin
            mode_d  = M_EATEN;
            timer_d = '0;
            eaten_d = 1'b1;
        end else if (power_pill && (mode_q != M_EATEN)) begin
            mode_d  = M_FRIGHT;
            timer_d = TW'(FRIGHT_FRAMES);
        end else begin
            case (mode_q)
                M_FRIGHT: if (frame_tick) begin
                    timer_d = (timer_q != '0) ? timer_q - TW'(1) : '0;
                    if (timer_d == TW'(FLASH_FRAMES)) mode_d = M_FLASH;
                end
                M_FLASH: if (frame_tick) begin
                    timer_d = (timer_q != '0) ? timer_q - TW'(1) : '0;
                    if (timer_d == '0) mode_d = M_NORMAL;
                end
                M_EATEN: if (ghost_home) mode_d = M_NORMAL;
                default: ;
            endcase
        end
    end

    // State and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q     <= M_NORMAL;
            timer_q    <= '0;
            anim_q     <= 1'b0;
            acnt_q     <= '0;
            armed_q    <= 1'b1;
            ghost_on_q <= 1'b0;
            color_q    <= 2'b00;
            killed_q   <= 1'b0;
            eaten_q    <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            timer_q    <= timer_d;
            anim_q     <= anim_d;
            acnt_q     <= acnt_d;
            armed_q    <= !collide;
            ghost_on_q <= ghost_on_d;
            color_q    <= color_d;
            killed_q   <= killed_d;
            eaten_q    <= eaten_d;
        end
    end

    assign ghost_on    = ghost_on_q;
    assign ghost_color = color_q;
    assign mode        = mode_q;
    assign pac_killed  = killed_q;
    assign ghost_eaten = eaten_q;

endmodule

// File: tb/tb_ghost_unit.sv
// Scoreboard bench for ghost_unit: the driver steps a frame-count based
// reference model and queues expected outputs; the monitor compares them.
module tb_ghost_unit;

    localparam int T  = 21;
    localparam int X0 = 100;
    localparam int Y0 = 9;
    localparam int FR = 360;
    localparam int FL = 120;
    localparam int AN = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, gameover, power_pill, frame_tick, ghost_home;
    logic [9:0] x;
    logic [8:0] y;
    logic [4:0] gx, gy, px, py;
    logic       ghost_on, pac_killed, ghost_eaten;
    logic [1:0] ghost_color, mode;

    logic [9:0] x2;
    logic [8:0] y2;
    logic [5:0] gx2, gy2, px2, py2;
    logic       zero2;
    logic       on2, k2, e2;
    logic [1:0] col2, mode2;

    ghost_unit #(.TILE(21), .X_ORIGIN(100), .Y_ORIGIN(9), .COORD_W(5),
                 .FRIGHT_FRAMES(360), .FLASH_FRAMES(120), .ANIM_FRAMES(8)) dut (
        .clk(clk), .reset(reset), .gameover(gameover), .power_pill(power_pill),
        .frame_tick(frame_tick), .x(x), .y(y), .ghost_x(gx), .ghost_y(gy),
        .pac_x(px), .pac_y(py), .ghost_home(ghost_home), .ghost_on(ghost_on),
        .ghost_color(ghost_color), .mode(mode), .pac_killed(pac_killed),
        .ghost_eaten(ghost_eaten));

    ghost_unit #(.TILE(16), .X_ORIGIN(0), .Y_ORIGIN(0), .COORD_W(6)) dut2 (
        .clk(clk), .reset(reset), .gameover(zero2), .power_pill(zero2),
        .frame_tick(zero2), .x(x2), .y(y2), .ghost_x(gx2), .ghost_y(gy2),
        .pac_x(px2), .pac_y(py2), .ghost_home(zero2), .ghost_on(on2),
        .ghost_color(col2), .mode(mode2), .pac_killed(k2), .ghost_eaten(e2));

    typedef struct {
        bit       on;
        bit [1:0] color;
        bit [1:0] mode;
        bit       killed;
        bit       eaten;
        bit       on2;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0;
    int          errors = 0;
    logic [20:0] bm[21];

    // Reference model state: frightened flag plus frames remaining.
    bit m_fright, m_eaten, m_armed;
    int m_rem, m_ticks;

    function automatic int ref_mode();
        if (m_eaten) return 3;
        if (m_fright) return (m_rem > FL) ? 1 : 2;
        return 0;
    endfunction

    function automatic bit ref_anim();
        return ((m_ticks / AN) % 2) == 1;
    endfunction

    function automatic bit sprite_px(int pxl, int pyl, int ox, int oy, int t,
                                     int g_x, int g_y, bit anim, bit eyes_only);
        int sx, sy;
        logic [20:0] r;
        sx = pxl - (ox + g_x * t);
        sy = pyl - (oy + g_y * t);
        if (sx < 0 || sx >= t || sy < 0 || sy >= t) return 1'b0;
        if (sx >= 21 || sy >= 21) return 1'b0;
        if (eyes_only && (sy < 5 || sy > 10)) return 1'b0;
        r = bm[sy];
        if (anim && (sy == 18 || sy == 19)) r = r >> 1;
        return r[20 - sx];
    endfunction

    task automatic model_cycle();
        exp_t e;
        int   cm;
        bit   coll;
        cm   = ref_mode();
        coll = (gx == px) && (gy == py);
        e.on = sprite_px(int'(x), int'(y), X0, Y0, T, int'(gx), int'(gy),
                         ref_anim(), cm == 3) && !gameover;
        case (cm)
            0: e.color = 2'd0;
            1: e.color = 2'd1;
            2: e.color = ref_anim() ? 2'd2 : 2'd1;
            default: e.color = 2'd3;
        endcase
        e.killed = coll && cm == 0 && !gameover && m_armed;
        e.eaten  = 1'b0;
        if (gameover) begin
            m_fright = 0; m_eaten = 0; m_rem = 0;
        end else if (coll && m_fright) begin
            m_fright = 0; m_eaten = 1; e.eaten = 1'b1;
        end else if (power_pill && !m_eaten) begin
            m_fright = 1; m_rem = FR;
        end else if (m_fright && frame_tick) begin
            m_rem--;
            if (m_rem == 0) m_fright = 0;
        end else if (m_eaten && ghost_home) begin
            m_eaten = 0;
        end
        if (frame_tick) m_ticks++;
        m_armed = !coll;
        e.mode  = 2'(ref_mode());
        e.on2   = sprite_px(int'(x2), int'(y2), 0, 0, 16, 39, 29, 1'b0, 1'b0);
        if (reset) begin
            m_fright = 0; m_eaten = 0; m_rem = 0; m_ticks = 0; m_armed = 1;
            e = '{default: '0};
        end
        sbq.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_cycle();
        #1;
    endtask

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
        end
    endtask

    // Monitor: pops one expectation per cycle once outputs have settled.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("ghost_on",    {1'b0, ghost_on},    {1'b0, e.on});
                chk("ghost_color", ghost_color,         e.color);
                chk("mode",        mode,                e.mode);
                chk("pac_killed",  {1'b0, pac_killed},  {1'b0, e.killed});
                chk("ghost_eaten", {1'b0, ghost_eaten}, {1'b0, e.eaten});
                chk("sweep_on",    {1'b0, on2},         {1'b0, e.on2});
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no end of stimulus, expected completion");
        $fatal(1);
    end

    task automatic rand_sweep_px();
        x2 = 10'($urandom_range(610, 660));
        y2 = 9'($urandom_range(455, 500));
    endtask

    task automatic rand_px();
        x = 10'(X0 + int'(gx) * T + $urandom_range(0, 27) - 3);
        y = 9'(Y0 + int'(gy) * T + $urandom_range(0, 27) - 3);
        rand_sweep_px();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1; rand_px(); cyc();
            frame_tick = 1'b0; rand_px(); cyc();
        end
    endtask

    initial begin
        bm[0]  = 21'b000000011111110000000;
        bm[1]  = 21'b000011111111111110000;
        bm[2]  = 21'b001111111111111111100;
        bm[3]  = 21'b011111111111111111110;
        bm[4]  = 21'b011111111111111111110;
        bm[5]  = 21'b111100111111111001111;
        for (int r = 6; r <= 9; r++) bm[r] = 21'b111000011111110000111;
        bm[10] = 21'b111100111111111001111;
        for (int r = 11; r <= 17; r++) bm[r] = 21'b111111111111111111111;
        bm[18] = 21'b110011100111001110011;
        bm[19] = 21'b100001100011000110001;
        bm[20] = 21'b000000000000000000000;

        m_fright = 0; m_eaten = 0; m_armed = 1; m_rem = 0; m_ticks = 0;
        reset = 1'b1; gameover = 1'b0; power_pill = 1'b0; frame_tick = 1'b0;
        ghost_home = 1'b0; x = '0; y = '0; gx = '0; gy = '0; px = 5'd5; py = 5'd5;
        x2 = '0; y2 = '0; gx2 = 6'd39; gy2 = 6'd29; px2 = '0; py2 = '0; zero2 = 1'b0;
        repeat (3) cyc();
        reset = 1'b0;

        // Full scan of the ghost at tile (0,0) plus one column past it.
        for (int yy = 9; yy <= 29; yy++) begin
            for (int xx = 100; xx <= 121; xx++) begin
                x = 10'(xx); y = 9'(yy); rand_sweep_px(); cyc();
            end
        end
        x = 10'd110; y = 9'd11; cyc();

        // Sweep instance: exact window corners and just outside them.
        for (int yy = 462; yy <= 481; yy++) begin
            for (int xx = 622; xx <= 641; xx++) begin
                x2 = 10'(xx); y2 = 9'(yy); cyc();
            end
        end

        // Full frightened period through flash back to normal.
        power_pill = 1'b1; cyc(); power_pill = 1'b0;
        ticks(FR);
        repeat (4) cyc();

        // Frightened collision -> eaten, eyes-only rendering, return home.
        power_pill = 1'b1; cyc(); power_pill = 1'b0;
        ticks(5);
        px = 5'd0; py = 5'd0; cyc();
        for (int yy = 9; yy <= 29; yy++) begin
            x = 10'd107; y = 9'(yy); frame_tick = yy[0]; cyc();
        end
        frame_tick = 1'b0; power_pill = 1'b1; cyc(); power_pill = 1'b0;
        ghost_home = 1'b1; cyc(); ghost_home = 1'b0;
        px = 5'd5; repeat (2) cyc();

        // Normal collision held for 10 clocks, separated, then re-overlapped.
        px = 5'd0; repeat (10) cyc();
        px = 5'd5; repeat (2) cyc();
        px = 5'd0; repeat (3) cyc();
        px = 5'd5; cyc();

        // Collision onset together with a power pill.
        px = 5'd0; power_pill = 1'b1; cyc(); power_pill = 1'b0;
        repeat (3) cyc();
        ghost_home = 1'b1; cyc(); ghost_home = 1'b0;
        px = 5'd5; cyc();

        // Gameover while frightened with the pixel inside the window.
        power_pill = 1'b1; cyc(); power_pill = 1'b0;
        ticks(3);
        gameover = 1'b1; x = 10'd110; y = 9'd11;
        px = 5'd0; repeat (3) cyc();
        px = 5'd5; repeat (2) cyc();
        gameover = 1'b0; cyc();

        // Reset in the middle of flashing.
        power_pill = 1'b1; cyc(); power_pill = 1'b0;
        frame_tick = 1'b1;
        for (int i = 0; i < 250; i++) begin rand_px(); cyc(); end
        frame_tick = 1'b0; x = 10'd110; y = 9'd11;
        reset = 1'b1; cyc(); reset = 1'b0;
        repeat (2) cyc();

        // Randomized mixed traffic.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                gx = 5'($urandom_range(0, 3)); gy = 5'($urandom_range(0, 3));
                px = 5'($urandom_range(0, 3)); py = 5'($urandom_range(0, 3));
            end
            power_pill = ($urandom_range(0, 149) == 0);
            frame_tick = ($urandom_range(0, 2) == 0);
            ghost_home = ($urandom_range(0, 19) == 0);
            gameover   = ($urandom_range(0, 299) == 0);
            reset      = ($urandom_range(0, 1999) == 0);
            rand_px();
            cyc();
        end
        reset = 1'b0; gameover = 1'b0; power_pill = 1'b0;
        frame_tick = 1'b0; ghost_home = 1'b0;

        repeat (3) @(negedge clk);
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, expected 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
